// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state encoding and default widths for the ALU sequencer.
package alu_seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_MAX  = 4'd7;
    localparam logic [3:0] OP_MIN  = 4'd8;
    localparam logic [3:0] OP_LAST = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_e;

    // Opcodes above OP_LAST are rejected in EXEC.
    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/wb_select.sv
// Writeback data select: the latched immediate or the captured ALU result.
module wb_select
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              use_imm_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] result_i,
    output logic [DATA_W-1:0] data_o
);

    assign data_o = use_imm_i ? imm_i : result_i;

endmodule

// File: rtl/alu_sequencer.sv
// Four-state sequencer: accept an instruction, read two registers, drive an
// external ALU, then write the result (or an immediate) back to the register file.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              register_clk,
    input  logic              register_rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_shift,
    input  logic              instr_use_imm,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] read_reg1,
    output logic [ADDR_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] alu_r1,
    output logic [DATA_W-1:0] alu_r2,
    output logic [4:0]        alu_shift,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] data_store,
    output logic              write_enable,
    output logic              done_valid,
    output logic [DATA_W-1:0] done_result,
    output logic              illegal_op,
    output logic              busy
);

    typedef struct packed {
        logic [3:0]        op;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] shift;
        logic              use_imm;
        logic [DATA_W-1:0] imm;
    } instr_t;

    state_e            state_q, state_d;
    instr_t            instr_q;
    logic [DATA_W-1:0] opnd1_q, opnd2_q;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] wb_data, store_q;
    logic [ADDR_W-1:0] write_reg_q;
    logic [3:0]        alu_op_q;
    logic [4:0]        alu_shift_q;
    logic              ready_q, illegal_q;
    logic              accept, exec_legal, in_wb;

    assign accept     = (state_q == IDLE) && ready_q && instr_valid;
    assign exec_legal = (state_q == EXEC) && op_is_legal(instr_q.op);
    assign in_wb      = (state_q == WB);

    // Next-state logic: one state per cycle, illegal opcodes return straight to IDLE.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = op_is_legal(instr_q.op) ? WB : IDLE;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MAX/MIN of equal operands must yield operand 1 regardless of what the ALU returns.
    always_comb begin
        result_d = alu_out;
        if ((instr_q.op == OP_MAX || instr_q.op == OP_MIN) && (opnd1_q == opnd2_q)) begin
            result_d = opnd1_q;
        end
    end

    wb_select #(.DATA_W(DATA_W)) u_wb_select (
        .use_imm_i (instr_q.use_imm),
        .imm_i     (instr_q.imm),
        .result_i  (result_q),
        .data_o    (wb_data)
    );

    // State register and the instruction fields latched on acceptance.
    always_ff @(posedge register_clk or negedge register_rst_n) begin
        if (!register_rst_n) begin
            state_q <= IDLE;
            instr_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            if (accept) begin
                instr_q <= '{op: instr_op, rs1: instr_rs1, rs2: instr_rs2, rd: instr_rd,
                             shift: instr_shift, use_imm: instr_use_imm, imm: instr_imm};
            end
        end
    end

    // Operand capture in READ, result capture in EXEC, writeback hold values in WB.
    always_ff @(posedge register_clk or negedge register_rst_n) begin
        if (!register_rst_n) begin
            opnd1_q     <= '0;
            opnd2_q     <= '0;
            alu_op_q    <= '0;
            alu_shift_q <= '0;
            result_q    <= '0;
            store_q     <= '0;
            write_reg_q <= '0;
        end else begin
            if (state_q == READ) begin
                opnd1_q     <= read_data1;
                opnd2_q     <= read_data2;
                alu_op_q    <= instr_q.op;
                alu_shift_q <= 5'(instr_q.shift);
            end
            if (exec_legal) begin
                result_q <= result_d;
            end
            if (in_wb) begin
                store_q     <= wb_data;
                write_reg_q <= instr_q.rd;
            end
        end
    end

    // Ready comes up one edge after reset release; illegal flag pulses the cycle after EXEC.
    always_ff @(posedge register_clk or negedge register_rst_n) begin
        if (!register_rst_n) begin
            ready_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ready_q   <= (state_d == IDLE);
            illegal_q <= (state_q == EXEC) && !op_is_legal(instr_q.op);
        end
    end

    assign instr_ready  = ready_q;
    assign busy         = (state_q != IDLE);
    assign read_reg1    = instr_q.rs1;
    assign read_reg2    = instr_q.rs2;
    assign alu_r1       = opnd1_q;
    assign alu_r2       = opnd2_q;
    assign alu_op       = alu_op_q;
    assign alu_shift    = alu_shift_q;
    assign write_enable = in_wb;
    assign done_valid   = in_wb;
    assign write_reg    = in_wb ? instr_q.rd : write_reg_q;
    assign data_store   = in_wb ? wb_data : store_q;
    assign done_result  = data_store;
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: bench-owned register file and ALU, directed scenarios
// followed by randomized instructions checked against a behavioural model.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [3:0]    instr_op = '0;
    logic [AW-1:0] instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0, instr_shift = '0;
    logic          instr_use_imm = 1'b0;
    logic [DW-1:0] instr_imm = '0;
    logic [AW-1:0] read_reg1, read_reg2, write_reg;
    logic [DW-1:0] read_data1, read_data2, alu_r1, alu_r2, alu_out;
    logic [DW-1:0] data_store, done_result;
    logic [4:0]    alu_shift;
    logic [3:0]    alu_op;
    logic          write_enable, done_valid, illegal_op, busy;

    logic [DW-1:0] rf [0:31];
    logic [DW-1:0] model_rf [0:31];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_count = 0;
    int exp_we = 0;
    int last_accept = 0;
    logic prev_we = 1'b0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .register_clk   (clk),
        .register_rst_n (rst_n),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_rs1      (instr_rs1),
        .instr_rs2      (instr_rs2),
        .instr_rd       (instr_rd),
        .instr_shift    (instr_shift),
        .instr_use_imm  (instr_use_imm),
        .instr_imm      (instr_imm),
        .read_reg1      (read_reg1),
        .read_reg2      (read_reg2),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .alu_r1         (alu_r1),
        .alu_r2         (alu_r2),
        .alu_shift      (alu_shift),
        .alu_op         (alu_op),
        .alu_out        (alu_out),
        .write_reg      (write_reg),
        .data_store     (data_store),
        .write_enable   (write_enable),
        .done_valid     (done_valid),
        .done_result    (done_result),
        .illegal_op     (illegal_op),
        .busy           (busy)
    );

    // Plain arithmetic definition of each opcode.
    function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [4:0] sh);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $unsigned($signed(a) >>> sh);
            OP_MAX:  return (a > b) ? a : b;
            OP_MIN:  return (a < b) ? a : b;
            default: return '0;
        endcase
    endfunction

    // Bench ALU; returns a wrong value for equal MAX/MIN so the sequencer override is observable.
    always_comb begin
        if ((alu_op == OP_MAX || alu_op == OP_MIN) && alu_r1 == alu_r2) alu_out = ~alu_r1;
        else alu_out = alu_fn(alu_op, alu_r1, alu_r2, alu_shift);
    end

    assign read_data1 = rf[read_reg1];
    assign read_data2 = rf[read_reg2];

    always @(posedge clk) begin
        if (poke_en) rf[poke_addr] <= poke_data;
        if (write_enable) rf[write_reg] <= data_store;
        cyc <= cyc + 1;
    end

    // Per-cycle invariants: write pulses last one cycle and done_valid tracks write_enable.
    always @(negedge clk) begin
        if (mon_en) begin
            check("we_one_cycle", write_enable & prev_we, 1'b0);
            check("done_vs_we", done_valid, write_enable);
            prev_we  <= write_enable;
            we_count <= we_count + int'(write_enable);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        model_rf[a] = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Offer one instruction, then check READ, EXEC and the completion cycle (N+3).
    // Returns at the falling edge inside cycle N+3. Optionally pokes a register
    // at the end of EXEC (after this instruction's operands are captured).
    task automatic issue(input logic [3:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic [AW-1:0] sh, input logic use_imm,
                         input logic [DW-1:0] imm, input bit keep_valid,
                         input bit do_poke, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
        logic [DW-1:0] a, b, exp;
        bit legal;
        int n;
        instr_op = op; instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
        instr_shift = sh; instr_use_imm = use_imm; instr_imm = imm;
        instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", instr_ready, 1'b1);
        a = model_rf[rs1];
        b = model_rf[rs2];
        legal = (op <= OP_LAST);
        exp = use_imm ? imm : alu_fn(op, a, b, 5'(sh));
        @(posedge clk);
        last_accept = cyc;
        #1;
        if (!keep_valid) instr_valid = 1'b0;
        @(negedge clk);
        check("read_busy", busy, 1'b1);
        check("read_ready", instr_ready, 1'b0);
        check("read_reg1", read_reg1, rs1);
        check("read_reg2", read_reg2, rs2);
        check("read_we", write_enable, 1'b0);
        @(negedge clk);
        check("exec_r1", alu_r1, a);
        check("exec_r2", alu_r2, b);
        check("exec_op", alu_op, op);
        check("exec_shift", alu_shift, sh);
        check("exec_we", write_enable, 1'b0);
        if (do_poke) begin
            poke_en = 1'b1; poke_addr = pa; poke_data = pd;
            model_rf[pa] = pd;
        end
        @(negedge clk);
        poke_en = 1'b0;
        if (legal) begin
            check("wb_we", write_enable, 1'b1);
            check("wb_done", done_valid, 1'b1);
            check("wb_reg", write_reg, rd);
            check("wb_data", data_store, exp);
            check("wb_result", done_result, exp);
            check("wb_illegal", illegal_op, 1'b0);
            check("wb_ready", instr_ready, 1'b0);
            model_rf[rd] = exp;
            exp_we++;
        end else begin
            check("ill_pulse", illegal_op, 1'b1);
            check("ill_we", write_enable, 1'b0);
            check("ill_ready", instr_ready, 1'b1);
            check("ill_busy", busy, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first_acc;
        // Reset state, with register file preloads happening under reset.
        #1;
        check("rst_ready", instr_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_we", write_enable, 1'b0);
        check("rst_illegal", illegal_op, 1'b0);
        for (int i = 0; i < 32; i++) preload(5'(i), $urandom);
        preload(5'd0, 32'd0);
        preload(5'd5, 32'd2);
        preload(5'd4, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_ready_low", instr_ready, 1'b0);
        @(posedge clk);
        #1;
        check("release_ready_high", instr_ready, 1'b1);
        mon_en = 1'b1;
        @(negedge clk);

        // ADD r5+r4 -> r15 = 3.
        issue(OP_ADD, 5'd5, 5'd4, 5'd15, 5'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        check("add_value", model_rf[15], 32'd3);

        // SUB then SRA back-to-back with valid held; r4 becomes all-ones before the SRA reads it.
        issue(OP_SUB, 5'd5, 5'd4, 5'd16, 5'd0, 1'b0, '0, 1'b1, 1'b1, 5'd4, 32'hFFFF_FFFF);
        first_acc = last_accept;
        issue(OP_SRA, 5'd4, 5'd5, 5'd17, 5'd1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        check("b2b_spacing", last_accept - first_acc, 4);
        check("sub_value", model_rf[16], 32'd1);
        check("sra_value", model_rf[17], 32'hFFFF_FFFF);

        // MAX/MIN with equal, then unequal operands.
        preload(5'd5, 32'd7);
        preload(5'd4, 32'd7);
        issue(OP_MAX, 5'd5, 5'd4, 5'd10, 5'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        issue(OP_MIN, 5'd5, 5'd4, 5'd11, 5'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        preload(5'd5, 32'd2);
        preload(5'd4, 32'd1);
        issue(OP_MAX, 5'd5, 5'd4, 5'd12, 5'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        issue(OP_MIN, 5'd5, 5'd4, 5'd13, 5'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        check("max_eq", model_rf[10], 32'd7);
        check("min_eq", model_rf[11], 32'd7);
        check("max_ne", model_rf[12], 32'd2);
        check("min_ne", model_rf[13], 32'd1);

        // Illegal opcode: pulse, no write.
        issue(4'd12, 5'd5, 5'd4, 5'd15, 5'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Immediate writeback, then read-after-write through the register file.
        issue(OP_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 1'b1, 32'd30, 1'b0, 1'b0, '0, '0);
        issue(OP_ADD, 5'd3, 5'd0, 5'd9, 5'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        check("imm_value", model_rf[3], 32'd30);
        check("raw_value", model_rf[9], 32'd30);

        // Reset during EXEC of an ADD aborts it.
        @(negedge clk);
        instr_op = OP_ADD; instr_rs1 = 5'd5; instr_rs2 = 5'd4; instr_rd = 5'd20;
        instr_use_imm = 1'b0; instr_valid = 1'b1;
        for (int n = 0; n < 20 && instr_ready !== 1'b1; n++) @(negedge clk);
        check("abort_accept", instr_ready, 1'b1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_exec", alu_r1, model_rf[5]);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready", instr_ready, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_we", write_enable, 1'b0);
        check("abort_reg1", read_reg1, '0);
        check("abort_r1", alu_r1, '0);
        check("abort_store", data_store, '0);
        check("abort_wreg", write_reg, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_rel_low", instr_ready, 1'b0);
        @(posedge clk);
        #1;
        check("abort_rel_high", instr_ready, 1'b1);
        repeat (4) @(negedge clk);
        check("abort_no_write", rf[20], model_rf[20]);

        // Randomized instructions against the model.
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            bit keep;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            keep = ($urandom_range(0, 3) == 0) && (i != 59);
            issue(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  ($urandom_range(0, 7) == 0), $urandom, keep, 1'b0, '0, '0);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("write_count", we_count, exp_we);
        for (int r = 0; r < 32; r++) check("rf_final", rf[r], model_rf[r]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DATA_W, 32, datapath and register width.
REQ-002 Parameter: ADDR_W, 5, register-file address width.
REQ-003 One clock; reset is asynchronous and active-low; clock port register_clk, reset port register_rst_n.
REQ-004 register_clk  in  1  rising-edge clock for all state.
REQ-005 register_rst_n  in  1  asynchronous active-low reset.
REQ-006 instr_valid  in  1  instruction offered; instr_ready  out  1  sequencer can accept.
REQ-007 instr_op  in  4  ALU opcode, 0..8 legal: ADD, SUB, AND, OR, SLL, SRL, SRA, MAX, MIN.
REQ-008 instr_rs1, instr_rs2, instr_rd, instr_shift  in  ADDR_W each  source regs, dest reg, shift amount.
REQ-009 instr_use_imm  in  1  write back instr_imm instead of ALU result; instr_imm  in  DATA_W.
REQ-010 read_reg1, read_reg2  out  ADDR_W; read_data1, read_data2  in  DATA_W  register-file read ports, combinational read.
REQ-011 alu_r1, alu_r2  out  DATA_W; alu_shift  out  5; alu_op  out  4; alu_out  in  DATA_W  ALU drive and result.
REQ-012 write_reg  out  ADDR_W; data_store  out  DATA_W; write_enable  out  1  register-file write port.
REQ-013 done_valid  out  1  one-cycle completion pulse; done_result  out  DATA_W  value written.
REQ-014 illegal_op  out  1  one-cycle pulse, opcode 9..15 rejected; busy  out  1  state != IDLE.

Function
REQ-015 FSM states IDLE, READ, EXEC, WB; one state per cycle; no other states.
REQ-016 IDLE: instr_ready=1; instr_valid&instr_ready at an edge latches all instr_* fields and moves to READ; instr_ready=0 in every other state.
REQ-017 READ: read_reg1/read_reg2 = latched rs1/rs2; read_data1/2 captured into operand registers at cycle end; next EXEC.
REQ-018 EXEC: alu_r1/alu_r2 = captured operands, alu_op/alu_shift = latched op/shift; alu_out captured at cycle end; next WB.
REQ-019 EXEC with opcode >8: no capture, illegal_op=1 for the following cycle, next IDLE, no write, no done_valid.
REQ-020 MAX/MIN with equal operands: captured result = operand 1 (sequencer overrides alu_out).
REQ-021 WB: write_enable=1, write_reg=latched rd, data_store = instr_use_imm ? latched imm : captured result; done_valid=1, done_result=data_store; next IDLE.
REQ-022 Latency: accept at edge N -> write_enable and done_valid high in cycle N+3 exactly one cycle; max throughput one instruction per 4 cycles.
REQ-023 Read-after-write: a write completes at the WB-ending edge, before any later instruction's READ cycle; no forwarding logic.
REQ-024 Register 0 is writable like any other; no hardwired zero.
REQ-025 write_enable, done_valid, illegal_op are 0 in every cycle not listed above; all other outputs hold last value when not driven.
REQ-026 Arithmetic is modulo 2^DATA_W; no overflow flag.

Reset
REQ-027 register_rst_n low: state=IDLE, all latched fields, operands, result and all outputs 0 asynchronously, including instr_ready=0.
REQ-028 instr_ready rises to 1 on the first rising edge after register_rst_n deasserts.
REQ-029 Reset mid-operation (any non-IDLE state) aborts the instruction: no write_enable, no done_valid, nothing pending after release.

Structure
REQ-030 Shared package alu_seq_pkg holds opcode constants OP_ADD=0..OP_MIN=8, OP_LAST=8, the FSM state enum and DATA_W/ADDR_W defaults.
REQ-031 One sub-module, wb_select: 2:1 DATA_W-bit writeback select (imm vs result); all else in alu_sequencer.

Verification
REQ-032 Preload r5=2, r4=1; issue ADD rs1=5 rs2=4 rd=15 -> write_enable in cycle N+3, write_reg=15, data_store=3, done_valid one cycle.
REQ-033 Same operands, SUB then SRA (r4=0xFFFFFFFF, shift=1, rs1=4) back-to-back valid held high -> second accepted 4 cycles after first; data_store 1 then 0xFFFFFFFF.
REQ-034 MAX and MIN with r5=r4=7 -> data_store=7 both; MAX r5=2,r4=1 -> 2; MIN -> 1.
REQ-035 instr_op=12 -> illegal_op pulse in cycle N+3, write_enable never asserted, instr_ready=1 in cycle N+3.
REQ-036 instr_use_imm=1, instr_imm=30, rd=3 -> data_store=30; next instruction reading r3 as rs1 with ADD r0=0 -> result 30.
REQ-037 Assert register_rst_n low during EXEC of an ADD -> outputs 0 immediately, no write to rd, instr_ready=1 one edge after release.
